// File: rtl/count_buffer_sequencer.sv
// Photon-count frame buffer: captures one sample per strobe into block RAM,
// then drains the frame in capture order over a valid/ready link.
module count_buffer_sequencer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              overrun,
  output logic [ADDR_W:0]   wr_count
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t state_reg, state_next;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic [ADDR_W:0]   len_reg, rd_ptr_reg, wr_count_reg, wr_inc;
  logic              q_valid_reg, tx_valid_reg, done_reg, err_len_reg, overrun_reg;
  logic [DATA_W-1:0] tx_data_reg;

  logic len_ok, accept_start, reject_start, do_write, handshake, last_hs, rd_issue;

  always_comb begin
    len_ok       = (frame_len != '0) && (frame_len <= DEPTH_L);
    accept_start = (state_reg == IDLE) && start && !abort && len_ok;
    reject_start = (state_reg == IDLE) && start && !abort && !len_ok;
    do_write     = (state_reg == CAPTURE) && sample_valid && !abort;
    wr_inc       = wr_count_reg + 1'b1;
    handshake    = (state_reg == DRAIN) && tx_valid_reg && tx_ready && !abort;
    // Every read has been issued, so the word being accepted is the final one.
    last_hs      = handshake && (rd_ptr_reg == len_reg);
    // At most one word in flight between RAM and the output register.
    rd_issue     = (state_reg == DRAIN) && !abort && (rd_ptr_reg != len_reg) &&
                   !q_valid_reg && (!tx_valid_reg || handshake);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_start) state_next = CAPTURE;
      CAPTURE: if (do_write && (wr_inc == len_reg)) state_next = DRAIN;
      DRAIN:   if (last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_reg      <= '0;
      rd_ptr_reg   <= '0;
      wr_count_reg <= '0;
      q_valid_reg  <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
      done_reg     <= 1'b0;
      err_len_reg  <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      done_reg    <= last_hs;
      err_len_reg <= reject_start;
      q_valid_reg <= rd_issue;
      if (accept_start) begin
        len_reg      <= frame_len;
        wr_count_reg <= '0;
        rd_ptr_reg   <= '0;
        overrun_reg  <= 1'b0;
      end
      if (do_write) wr_count_reg <= wr_inc;
      if (rd_issue) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if ((state_reg == DRAIN) && sample_valid && !abort) overrun_reg <= 1'b1;
      if (abort) begin
        tx_valid_reg <= 1'b0;
      end else if (q_valid_reg) begin
        tx_valid_reg <= 1'b1;
        tx_data_reg  <= ram_q;
      end else if (handshake) begin
        tx_valid_reg <= 1'b0;
      end
    end
  end

  // Plain synchronous RAM with registered read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_count_reg[ADDR_W-1:0]] <= sample_data;
    ram_q <= mem[rd_ptr_reg[ADDR_W-1:0]];
  end

  assign tx_valid = tx_valid_reg;
  assign tx_data  = tx_data_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign err_len  = err_len_reg;
  assign overrun  = overrun_reg;
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_count_buffer_sequencer.sv
// Directed bench for count_buffer_sequencer: capture, drain, length errors,
// abort, overrun and mid-drain reset.
module tb_count_buffer_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [10:0] frame_len;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        busy;
  logic        done;
  logic        err_len;
  logic        overrun;
  logic [10:0] wr_count;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] exp_mem [1024];

  count_buffer_sequencer #(.DATA_W(16), .DEPTH(1024), .ADDR_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .frame_len    (frame_len),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .done         (done),
    .err_len      (err_len),
    .overrun      (overrun),
    .wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [10:0] len);
    start     = 1'b1;
    frame_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] val);
    sample_valid = 1'b1;
    sample_data  = val;
    tick();
    sample_valid = 1'b0;
  endtask

  // Accepts n words against exp_mem, checking hold-while-stalled and the done pulse.
  task automatic drain(input int n, input logic [15:0] rdy_pat, input string tag);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    bit          fin = 1'b0;
    logic [15:0] held = '0;
    while (!fin && cyc < 5000) begin
      if (stalled) begin
        check({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_hold_data"}, 32'(tx_data), 32'(held));
      end
      tx_ready = rdy_pat[cyc % 16];
      stalled  = tx_valid && !tx_ready;
      held     = tx_data;
      if (tx_valid && tx_ready) begin
        check({tag, "_word"}, 32'(tx_data), 32'(exp_mem[got]));
        got++;
      end
      tick();
      cyc++;
      if (got == n) begin
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_valid_drop"}, 32'(tx_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        fin = 1'b1;
      end else begin
        check({tag, "_no_early_done"}, 32'(done), 32'd0);
      end
    end
    tx_ready = 1'b0;
    if (!fin) check({tag, "_timeout_words"}, 32'(got), 32'(n));
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_no_extra_word"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    frame_len    = '0;
    sample_valid = 1'b0;
    sample_data  = '0;
    tx_ready     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_len", 32'(err_len), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    rst = 1'b1;
    tick();

    // T1: len 4, always ready, first word exactly 2 cycles after DRAIN entry
    start_frame(11'd4);
    check("t1_busy", 32'(busy), 32'd1);
    exp_mem[0] = 16'd10; exp_mem[1] = 16'd20; exp_mem[2] = 16'd30; exp_mem[3] = 16'd40;
    for (int i = 0; i < 4; i++) strobe(exp_mem[i]);
    check("t1_wr_count", 32'(wr_count), 32'd4);
    check("t1_entry_valid", 32'(tx_valid), 32'd0);
    tick();
    check("t1_entry1_valid", 32'(tx_valid), 32'd0);
    tick();
    check("t1_first_valid", 32'(tx_valid), 32'd1);
    check("t1_first_data", 32'(tx_data), 32'd10);
    drain(4, 16'hFFFF, "t1");
    check("t1_wr_hold", 32'(wr_count), 32'd4);

    // T2: len 3 with an irregular ready pattern
    start_frame(11'd3);
    exp_mem[0] = 16'h0111; exp_mem[1] = 16'h0222; exp_mem[2] = 16'h0333;
    for (int i = 0; i < 3; i++) strobe(exp_mem[i]);
    drain(3, 16'b1011_0010_1100_1000, "t2");

    // T3: illegal lengths, then a full-depth frame
    start_frame(11'd0);
    check("t3_err_len0", 32'(err_len), 32'd1);
    check("t3_busy_len0", 32'(busy), 32'd0);
    tick();
    check("t3_err_clear", 32'(err_len), 32'd0);
    start_frame(11'd1025);
    check("t3_err_len1025", 32'(err_len), 32'd1);
    check("t3_busy_len1025", 32'(busy), 32'd0);
    tick();
    check("t3_err_clear2", 32'(err_len), 32'd0);
    start_frame(11'd1024);
    check("t3_busy_full", 32'(busy), 32'd1);
    for (int i = 0; i < 1024; i++) begin
      exp_mem[i] = 16'(i);
      strobe(16'(i));
    end
    check("t3_wr_count", 32'(wr_count), 32'd1024);
    drain(1024, 16'hFFFF, "t3");

    // T4: abort together with the 6th strobe, then a fresh len 2 frame
    start_frame(11'd8);
    for (int i = 0; i < 5; i++) strobe(16'h00A0 + 16'(i));
    sample_valid = 1'b1;
    sample_data  = 16'h00EE;
    abort        = 1'b1;
    tick();
    sample_valid = 1'b0;
    abort        = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_tx_valid", 32'(tx_valid), 32'd0);
    check("t4_wr_count", 32'(wr_count), 32'd5);
    check("t4_no_done", 32'(done), 32'd0);
    tick();
    check("t4_no_done2", 32'(done), 32'd0);
    start_frame(11'd2);
    check("t4_wr_cleared", 32'(wr_count), 32'd0);
    exp_mem[0] = 16'h1234; exp_mem[1] = 16'h5678;
    strobe(exp_mem[0]);
    strobe(exp_mem[1]);
    drain(2, 16'b0101_0101_0101_0110, "t4");

    // T5: strobe during DRAIN sets overrun without disturbing data
    start_frame(11'd3);
    exp_mem[0] = 16'd7; exp_mem[1] = 16'd8; exp_mem[2] = 16'd9;
    for (int i = 0; i < 3; i++) strobe(exp_mem[i]);
    check("t5_overrun_pre", 32'(overrun), 32'd0);
    strobe(16'h0099);
    check("t5_overrun", 32'(overrun), 32'd1);
    check("t5_wr_count", 32'(wr_count), 32'd3);
    drain(3, 16'hFFFF, "t5");
    check("t5_overrun_sticky", 32'(overrun), 32'd1);
    start_frame(11'd1);
    check("t5_overrun_cleared", 32'(overrun), 32'd0);
    strobe(16'h0055);
    tick();
    tick();
    check("t5_len1_valid", 32'(tx_valid), 32'd1);
    check("t5_len1_data", 32'(tx_data), 32'h55);
    #2;
    rst = 1'b0;
    #1;
    check("t5_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_tx_data", 32'(tx_data), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_wr_count", 32'(wr_count), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("t5_post_rst_done", 32'(done), 32'd0);
    check("t5_post_rst_valid", 32'(tx_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
